mux8_rr_arbiter: RTL
====================

Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 selected output line among 8 requesters. It sequences the select of an 8:1 multiplexer and enforces a maximum hold time per grant. It inserts a one-cycle break-before-make gap between grants. The block sits in front of the existing mux_8x1 cell, which it instantiates, and drives y only while a grant is active.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles when another requester is waiting; legal range 1..2**CNT_W
CNT_W, 3, width of the hold counter

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
req  input  8  request lines, bit i = requester i
d  input  8  data lines, bit i = requester i's data
gnt  output  8  one-hot grant, registered
s  output  3  mux select (index of current/last grantee), registered
valid  output  1  high while a grant is active (state GRANT)
y  output  1  d[s] AND valid

Behaviour:
- One clock (clk). Reset is synchronous and active-high: sampled only on the rising edge of clk, and it overrides all other inputs.
- Reset values: state=IDLE, gnt=8'h00, s=3'd0, valid=0, y=0, ptr=3'd0, cnt=0.
- ptr is the highest-priority index. The search order is ptr, ptr+1, ... wrapping mod 8.
- States (2-bit): IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, pick the first set bit i in search order.
  - Next edge: state=GRANT, gnt=onehot(i), s=i, valid=1, cnt=0.
  - Otherwise stay in IDLE.
  - Latency: req asserted before edge k gives gnt high after edge k (one cycle).
- GRANT:
  - Each edge, evaluate release = (req[s]==0) OR (cnt==MAX_HOLD-1 AND (req & ~gnt)!=0).
  - On release, next edge: state=GAP, gnt=0, valid=0, ptr=s+1 mod 8 (7 wraps to 0), s holds.
  - Otherwise, cnt increments, saturating at MAX_HOLD-1. A lone requester therefore holds indefinitely.
  - When preempted, the grantee is granted for exactly MAX_HOLD cycles.
- Simultaneous events:
  - Grantee drops req in the same cycle the hold limit is hit: one release, normal GAP.
  - Other req bits changing during GRANT: no effect until the next arbitration.
- GAP:
  - Lasts exactly one cycle, with gnt=0 and valid=0.
  - Next edge arbitrates exactly as IDLE, using the updated ptr. If req != 0, go to GRANT; else go to IDLE.
  - Minimum dead time between two grants is 1 cycle.
- y is combinational: mux_8x1 output on (s, d), ANDed with valid. y=0 in IDLE and GAP.
- Reset mid-operation (any state): next edge returns all outputs to their reset values, including ptr=0. No partial grant completes.
- gnt is always zero or one-hot. When valid=1, gnt == onehot(s).

Decomposition:
- Shared header (`define include): state encodings IDLE=2'b00, GRANT=2'b01, GAP=2'b10, plus the requester count 8 and select width 3.
- Sub-module rr_pick8: combinational find-first-set from ptr with wrap.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
- The existing mux_8x1 is instantiated for y. The top level holds the FSM, ptr, cnt and registered outputs.

Test Plan:
- Reset held 2 cycles, req=8'hFF -> gnt=00, s=0, valid=0, y=0 throughout. First edge after reset release gives gnt=01, s=0.
- req=8'h04, d=8'h04 from cycle 1 -> cycle 2: gnt=04, s=2, valid=1, y=1. Drop req[2] -> following cycle gnt=00, valid=0 (GAP), then IDLE.
- MAX_HOLD=4, req=8'h81 constant -> repeating sequence: gnt=01 for 4 cycles, 00 for 1, 80 for 4, 00 for 1, then 01 again.
- req=8'h01 held 10 cycles (no competitor) -> gnt=01 continuously for 10 cycles, no GAP. A GAP follows only when req[0] drops.
- req=8'hFF, MAX_HOLD=1 -> s sequence 0,1,2,...,7,0 with one GAP between each grant. This checks the wrap from 7 to 0.
- Reset asserted while gnt=08 -> next cycle gnt=00 and ptr=0. Then req=8'h06 -> gnt=02 (s=1), not 04.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_rr_arbiter shared definitions.
// State encodings, requester geometry and small helpers.
package mux8_rr_arbiter_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter requester/grant bundle.
// master drives requests and data, slave is the arbiter.
interface mux8_rr_arbiter_if
    import mux8_rr_arbiter_pkg::*;
;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  d;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] s;
    logic             valid;
    logic             y;

    modport master (
        output req,
        output d,
        input  gnt,
        input  s,
        input  valid,
        input  y
    );

    modport slave (
        input  req,
        input  d,
        output gnt,
        output s,
        output valid,
        output y
    );
endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8 rotating priority picker.
// First set request at or after ptr, wrapping mod 8.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] idx_o
);
    logic [SEL_W-1:0] cand;
    logic             found;

    // Walk from ptr upward; the first hit wins.
    always_comb begin
        any_o = |req_i;
        idx_o = ptr_i;
        found = 1'b0;
        cand  = ptr_i;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_i + SEL_W'(k);
            if (!found && req_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_8x1.sv
// mux_8x1 cell.
// Plain 8:1 single-bit multiplexer.
module mux_8x1 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);
    assign y = d[s];
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter top.
// Round-robin grant FSM with hold limit and one-cycle gap.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input logic              clk,
    input logic              reset,
    mux8_rr_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             others_w;
    logic             release_w;
    logic             mux_y;
    logic             valid_w;

    rr_pick8 u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    mux_8x1 u_mux (
        .d (bus.d),
        .s (s_q),
        .y (mux_y)
    );

    assign others_w  = |(bus.req & ~gnt_q);
    assign release_w = ~bus.req[s_q]
                     | ((cnt_q == HOLD_LAST) & others_w);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate from IDLE/GAP, leave GRANT on release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, GAP: state_d = pick_any ? GRANT : IDLE;
            GRANT:     state_d = release_w ? GAP : GRANT;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of grant, select, pointer and hold counter.
    always_comb begin
        gnt_d = gnt_q;
        s_d   = s_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        unique case (state_q)
            IDLE, GAP: begin
                gnt_d = '0;
                if (pick_any) begin
                    gnt_d = onehot(pick_idx);
                    s_d   = pick_idx;
                    cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    gnt_d = '0;
                    ptr_d = s_q + SEL_W'(1);
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // Registered grant outputs and arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q <= '0;
            s_q   <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            s_q   <= s_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_w   = (state_q == GRANT);
    assign bus.gnt   = gnt_q;
    assign bus.s     = s_q;
    assign bus.valid = valid_w;
    assign bus.y     = mux_y & valid_w;
endmodule
